// File: rtl/sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor: FSM state encoding
// and the bit-counter width calculation.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter must index bits 0..w-1; keep at least one bit for tiny widths.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bi, bo = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing D = A - B - Bin, LSB first, one bit per clock,
// with a start/done handshake around a single full-subtractor cell.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] r_sr;
  logic             d_bit;
  logic             bo_bit;
  logic [WIDTH-1:0] r_full;

  full_subtractor u_fs (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bi (borrow),
    .d  (d_bit),
    .bo (bo_bit)
  );

  // Current bit joins the partial result; on the last bit this is the full difference.
  assign r_full = {d_bit, r_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      D      <= '0;
      Bout   <= 1'b0;
      cnt    <= '0;
      borrow <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            borrow <= Bin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          r_sr   <= r_full[WIDTH-1:1];
          borrow <= bo_bit;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            D     <= r_full;
            Bout  <= bo_bit;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboarded bench for serial_subtractor (WIDTH=4): handshake timing, table
// vectors, boundaries, busy-ignore, back-to-back, async reset abort and full sweep.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic         Bin   = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bout;

  logic [W:0] exp_q[$];
  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W:0]   e;
    string        name;
  } vec_t;

  vec_t vecs[6];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout)
  );

  always #5 clk = ~clk;

  // Present operands for one accepting edge, then scramble them.
  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                    input logic [W:0] e);
    @(negedge clk);
    A = a; B = b; Bin = bi; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
  endtask

  task automatic wait_done(output bit ok, output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = done;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, Bout, D} !== '0) begin
      fails++;
      $display("FAIL reset_state: got busy=%b done=%b Bout=%b D=%b, want all 0", busy, done, Bout, D);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_timing();
    int n = 0;
    int busy_cnt = 0;
    logic [W:0] e;
    go(4'b0101, 4'b0011, 1'b0, 5'b0_0010);
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL basic_timeout: done=%b after %0d cycles, want 1", done, n);
    end else begin
      checks++;
      if (n != W) begin
        fails++;
        $display("FAIL basic_latency: done after %0d edges past accept, want %0d", n, W);
      end
      checks++;
      if (busy_cnt != W) begin
        fails++;
        $display("FAIL basic_busy_len: busy for %0d cycles, want %0d", busy_cnt, W);
      end
      e = exp_q.pop_front();
      checks++;
      if ({Bout, D} !== e) begin
        fails++;
        $display("FAIL basic_result: got %b_%b, want %b_%b", Bout, D, e[W], e[W-1:0]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {Bout, D} !== e) begin
        fails++;
        $display("FAIL basic_pulse_hold: done=%b busy=%b result=%b_%b, want 0 0 %b_%b",
                 done, busy, Bout, D, e[W], e[W-1:0]);
      end
    end
  endtask

  task automatic test_vectors();
    bit ok;
    int n;
    logic [W:0] e;
    vecs[0] = '{4'b0011, 4'b0101, 1'b0, 5'b1_1110, "neg_result"};
    vecs[1] = '{4'b1000, 4'b0111, 1'b1, 5'b0_0000, "zero_with_bin"};
    vecs[2] = '{4'b0000, 4'b0000, 1'b1, 5'b1_1111, "bnd_zero_bin"};
    vecs[3] = '{4'b1111, 4'b0001, 1'b0, 5'b0_1110, "bnd_max_minus1"};
    vecs[4] = '{4'b1111, 4'b1111, 1'b1, 5'b1_1111, "bnd_max_max_bin"};
    vecs[5] = '{4'b0101, 4'b0011, 1'b0, 5'b0_0010, "repeat_basic"};
    for (int i = 0; i < 6; i++) begin
      go(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].e);
      wait_done(ok, n);
      checks++;
      if (!ok) begin
        fails++;
        $display("FAIL %s_timeout: done=%b, want 1", vecs[i].name, done);
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ({Bout, D} !== e) begin
          fails++;
          $display("FAIL %s: got %b_%b, want %b_%b", vecs[i].name, Bout, D, e[W], e[W-1:0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    logic [W:0] e;
    go(4'b0110, 4'b0010, 1'b0, 5'b0_0100);
    // Second start arrives while busy and must be ignored.
    A = 4'b0001; B = 4'b0100; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    wait_done(ok, n);
    checks++;
    if (!ok || n != W - 2) begin
      fails++;
      $display("FAIL ignore_latency: ok=%b n=%0d, want ok=1 n=%0d", ok, n, W - 2);
    end
    if (ok) begin
      e = exp_q.pop_front();
      checks++;
      if ({Bout, D} !== e) begin
        fails++;
        $display("FAIL ignore_result: got %b_%b, want %b_%b", Bout, D, e[W], e[W-1:0]);
      end
      // Start held during the DONE cycle is accepted immediately.
      A = 4'b0010; B = 4'b0011; Bin = 1'b0; start = 1'b1;
      exp_q.push_back(5'b1_1111);
      @(negedge clk);
      start = 1'b0;
      A = '0; B = '0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL b2b_accept: busy=%b done=%b, want busy=1 done=0", busy, done);
      end
      checks++;
      if ({Bout, D} !== 5'b0_0100) begin
        fails++;
        $display("FAIL b2b_hold_prev: got %b_%b, want 0_0100 during shift", Bout, D);
      end
      wait_done(ok, n);
      checks++;
      if (!ok || n != W) begin
        fails++;
        $display("FAIL b2b_latency: ok=%b n=%0d, want ok=1 n=%0d", ok, n, W);
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ({Bout, D} !== e) begin
          fails++;
          $display("FAIL b2b_result: got %b_%b, want %b_%b", Bout, D, e[W], e[W-1:0]);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    int n;
    int spurious = 0;
    logic [W:0] e;
    go(4'b1010, 4'b0001, 1'b0, 5'b0_1001);
    @(negedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre_busy: busy=%b, want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, Bout, D} !== '0) begin
      fails++;
      $display("FAIL abort_async: got busy=%b done=%b Bout=%b D=%b, want all 0", busy, done, Bout, D);
    end
    void'(exp_q.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      fails++;
      $display("FAIL abort_no_done: saw %0d done pulses, want 0", spurious);
    end
    go(4'b1001, 4'b0100, 1'b0, 5'b0_0101);
    wait_done(ok, n);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL abort_recover_timeout: done=%b, want 1", done);
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({Bout, D} !== e) begin
        fails++;
        $display("FAIL abort_recover: got %b_%b, want %b_%b", Bout, D, e[W], e[W-1:0]);
      end
    end
  endtask

  task automatic test_sweep();
    bit ok;
    int n;
    int bad = 0;
    logic [W:0] e;
    logic [W:0] model;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        for (int bi = 0; bi < 2; bi++) begin
          model = (W+1)'(a - b - bi);
          go(W'(a), W'(b), 1'(bi), model);
          wait_done(ok, n);
          checks++;
          if (!ok) begin
            fails++;
            $display("FAIL sweep_timeout: a=%0d b=%0d bin=%0d", a, b, bi);
            exp_q.delete();
          end else begin
            e = exp_q.pop_front();
            checks++;
            if ({Bout, D} !== e) begin
              fails++;
              bad++;
              if (bad < 10)
                $display("FAIL sweep a=%0d b=%0d bin=%0d: got %b_%b, want %b_%b",
                         a, b, bi, Bout, D, e[W], e[W-1:0]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_timing();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
